// File: rtl/fifo_pkg.sv
// Shared sizing helpers, parameter legality checks and status typedefs for the
// parametrised synchronous FIFO slice.
package fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // One extra bit so the count can represent DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return ptr_w(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int unsigned dwidth, input int unsigned depth,
                                   input int unsigned af_level, input int unsigned ae_level);
    return (dwidth >= 1) && is_pow2(depth) &&
           (af_level >= 1) && (af_level <= depth) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param; the FIFO takes the
// slave view, the surrounding logic (or bench) the master view.
interface sync_fifo_param_if #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned DEPTH  = 8
) ();
  localparam int unsigned CW = fifo_pkg::cnt_w(DEPTH);

  logic              wr_en;
  logic [DWIDTH-1:0] data_in;
  logic              rd_en;
  logic [DWIDTH-1:0] data_out;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port. A read and
// write to the same address on one edge return the old word.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [DWIDTH-1:0]         wdata,
  input  logic                      re,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [DWIDTH-1:0]         rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left unreset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: pointers, occupancy counter, threshold flags and
// overflow/underflow pulses around a registered-read dual-port RAM.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_param_if.slave   bus
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  generate
    if (!params_ok(DWIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
      $error("sync_fifo_param: illegal DWIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end
  endgenerate

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          wr_acc;
  logic          rd_acc;
  fifo_op_e      op;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A write into a full FIFO is legal when a read frees the slot on the same edge.
  always_comb begin
    wr_acc = bus.wr_en && (!full || bus.rd_en);
    rd_acc = bus.rd_en && !empty;
    op     = fifo_op_e'({wr_acc, rd_acc});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.rd_valid  <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case (op)
        OP_WR:   count <= count + CW'(1);
        OP_RD:   count <= count - CW'(1);
        default: count <= count;
      endcase
      bus.rd_valid  <= rd_acc;
      bus.overflow  <= bus.wr_en && full && !bus.rd_en;
      bus.underflow <= bus.rd_en && empty;
    end
  end

  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count <= CW'(AE_LEVEL));

  fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (bus.data_out)
  );

endmodule
